// File: rtl/multiple_xfer_sequencer_pkg.sv
// Shared types and constants for the Thumb block-transfer sequencer.
// Opcode fields match the 16-bit LDM/STM and PUSH/POP encodings.
package multiple_xfer_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WB
    } state_t;

    localparam logic [3:0] OP_LDMSTM   = 4'b1100;
    localparam logic [3:0] OP_MISC     = 4'b1011;
    localparam logic [1:0] PUSHPOP_SEL = 2'b10;

    localparam int REG_SP = 13;
    localparam int REG_LR = 14;
    localparam int REG_PC = 15;

endpackage

// File: rtl/multiple_xfer_sequencer_if.sv
// Decode-side and load/store-side signals of the block-transfer sequencer.
// The sequencer uses the slave modport; whoever drives decode uses master.
interface multiple_xfer_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [15:0]       instruction16_in;
    logic              multiple_pulse;
    logic [ADDR_W-1:0] base_value;
    logic              mem_ready;
    logic              stall;
    logic              busy;
    logic              xfer_valid;
    logic              xfer_write;
    logic [3:0]        xfer_reg;
    logic [ADDR_W-1:0] xfer_addr;
    logic              wb_valid;
    logic [3:0]        wb_reg;
    logic [ADDR_W-1:0] wb_value;
    logic              done;

    modport master (
        output instruction16_in, multiple_pulse, base_value, mem_ready,
        input  stall, busy, xfer_valid, xfer_write, xfer_reg, xfer_addr,
               wb_valid, wb_reg, wb_value, done
    );

    modport slave (
        input  instruction16_in, multiple_pulse, base_value, mem_ready,
        output stall, busy, xfer_valid, xfer_write, xfer_reg, xfer_addr,
               wb_valid, wb_reg, wb_value, done
    );

endinterface

// File: rtl/multiple_xfer_sequencer_lowest_set_bit9.sv
// 9-bit priority encoder: index of the lowest set bit plus its one-hot mask.
// An all-zero input yields index 0 and an empty mask.
module lowest_set_bit9 (
    input  logic [8:0] bits,
    output logic [3:0] idx,
    output logic [8:0] mask
);

    always_comb begin
        idx  = '0;
        mask = '0;
        for (int i = 8; i >= 0; i--) begin
            if (bits[i]) begin
                idx  = 4'(i);
                mask = 9'(1) << i;
            end
        end
    end

endmodule

// File: rtl/multiple_xfer_sequencer.sv
// Expands one Thumb LDM/STM/PUSH/POP into ascending per-register transfers,
// stalling decode while it runs, then strobes the base-register writeback.
module multiple_xfer_sequencer
    import multiple_xfer_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SP_IDX = REG_SP,
    parameter int LR_IDX = REG_LR,
    parameter int PC_IDX = REG_PC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multiple_xfer_sequencer_if.slave bus
);

    state_t            state_q, state_d;
    logic [8:0]        list_q, list_d;
    logic [8:0]        cur_mask_q, cur_mask_d;
    logic              wb_en_q, wb_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              xfer_valid_q, xfer_valid_d;
    logic              xfer_write_q, xfer_write_d;
    logic [3:0]        xfer_reg_q, xfer_reg_d;
    logic [ADDR_W-1:0] xfer_addr_q, xfer_addr_d;
    logic              wb_valid_q, wb_valid_d;
    logic [3:0]        wb_reg_q, wb_reg_d;
    logic [ADDR_W-1:0] wb_value_q, wb_value_d;

    logic [8:0]        dec_list;
    logic              dec_load;
    logic              dec_ldm;
    logic              dec_push;
    logic [3:0]        dec_n;
    logic [3:0]        dec_wb_reg;
    logic [ADDR_W-1:0] four_n;
    logic [ADDR_W-1:0] dec_start;
    logic [ADDR_W-1:0] dec_wb_value;
    logic              dec_wb_en;

    logic [8:0]        next_list;
    logic              next_load;
    logic [3:0]        enc_idx;
    logic [8:0]        enc_mask;
    logic [3:0]        next_reg;

    // PUSH stores below SP so the lowest register lands at the lowest address.
    always_comb begin
        dec_list   = '0;
        dec_load   = 1'b0;
        dec_ldm    = 1'b0;
        dec_push   = 1'b0;
        dec_wb_reg = '0;
        if (bus.instruction16_in[15:12] == OP_LDMSTM) begin
            dec_list   = {1'b0, bus.instruction16_in[7:0]};
            dec_load   = bus.instruction16_in[11];
            dec_ldm    = bus.instruction16_in[11];
            dec_wb_reg = {1'b0, bus.instruction16_in[10:8]};
        end else if (bus.instruction16_in[15:12] == OP_MISC &&
                     bus.instruction16_in[10:9] == PUSHPOP_SEL) begin
            dec_list   = bus.instruction16_in[8:0];
            dec_load   = bus.instruction16_in[11];
            dec_push   = ~bus.instruction16_in[11];
            dec_wb_reg = 4'(SP_IDX);
        end
        dec_n = '0;
        for (int i = 0; i < 9; i++) begin
            dec_n = dec_n + 4'(dec_list[i]);
        end
        four_n       = ADDR_W'(dec_n) << 2;
        dec_start    = dec_push ? bus.base_value - four_n : bus.base_value;
        dec_wb_value = dec_push ? bus.base_value - four_n : bus.base_value + four_n;
        dec_wb_en    = (dec_n != 4'd0) &&
                       !(dec_ldm && dec_list[bus.instruction16_in[10:8]]);
    end

    // The encoder looks at the list as it will be after this cycle, so the
    // registered xfer_reg is already correct when the state advances.
    assign next_list = (state_q == IDLE) ? dec_list : (list_q & ~cur_mask_q);
    assign next_load = (state_q == IDLE) ? dec_load : ~xfer_write_q;

    lowest_set_bit9 u_lsb (
        .bits (next_list),
        .idx  (enc_idx),
        .mask (enc_mask)
    );

    assign next_reg = (enc_idx == 4'd8) ? (next_load ? 4'(PC_IDX) : 4'(LR_IDX))
                                        : enc_idx;

    always_comb begin
        state_d      = state_q;
        list_d       = list_q;
        cur_mask_d   = cur_mask_q;
        wb_en_d      = wb_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        xfer_valid_d = xfer_valid_q;
        xfer_write_d = xfer_write_q;
        xfer_reg_d   = xfer_reg_q;
        xfer_addr_d  = xfer_addr_q;
        wb_valid_d   = 1'b0;
        wb_reg_d     = wb_reg_q;
        wb_value_d   = wb_value_q;
        case (state_q)
            IDLE: begin
                if (bus.multiple_pulse) begin
                    list_d     = next_list;
                    cur_mask_d = enc_mask;
                    wb_en_d    = dec_wb_en;
                    wb_reg_d   = dec_wb_reg;
                    wb_value_d = dec_wb_value;
                    busy_d     = 1'b1;
                    if (dec_n != 4'd0) begin
                        state_d      = XFER;
                        xfer_valid_d = 1'b1;
                        xfer_write_d = ~dec_load;
                        xfer_reg_d   = next_reg;
                        xfer_addr_d  = dec_start;
                    end else begin
                        state_d = WB;
                        done_d  = 1'b1;
                    end
                end
            end
            XFER: begin
                if (bus.mem_ready) begin
                    list_d      = next_list;
                    cur_mask_d  = enc_mask;
                    xfer_addr_d = xfer_addr_q + ADDR_W'(4);
                    xfer_reg_d  = next_reg;
                    if (next_list == 9'd0) begin
                        state_d      = WB;
                        xfer_valid_d = 1'b0;
                        xfer_write_d = 1'b0;
                        xfer_reg_d   = '0;
                        xfer_addr_d  = '0;
                        wb_valid_d   = wb_en_q;
                        done_d       = 1'b1;
                    end
                end
            end
            WB: begin
                state_d    = IDLE;
                list_d     = '0;
                cur_mask_d = '0;
                wb_en_d    = 1'b0;
                busy_d     = 1'b0;
                wb_reg_d   = '0;
                wb_value_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            list_q       <= '0;
            cur_mask_q   <= '0;
            wb_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            xfer_valid_q <= 1'b0;
            xfer_write_q <= 1'b0;
            xfer_reg_q   <= '0;
            xfer_addr_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_reg_q     <= '0;
            wb_value_q   <= '0;
        end else begin
            state_q      <= state_d;
            list_q       <= list_d;
            cur_mask_q   <= cur_mask_d;
            wb_en_q      <= wb_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            xfer_valid_q <= xfer_valid_d;
            xfer_write_q <= xfer_write_d;
            xfer_reg_q   <= xfer_reg_d;
            xfer_addr_q  <= xfer_addr_d;
            wb_valid_q   <= wb_valid_d;
            wb_reg_q     <= wb_reg_d;
            wb_value_q   <= wb_value_d;
        end
    end

    assign bus.stall      = bus.multiple_pulse | busy_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.xfer_valid = xfer_valid_q;
    assign bus.xfer_write = xfer_write_q;
    assign bus.xfer_reg   = xfer_reg_q;
    assign bus.xfer_addr  = xfer_addr_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_reg     = wb_reg_q;
    assign bus.wb_value   = wb_value_q;

endmodule
